// File: rtl/de10_standard_qsys_irq_pkg.sv
// Shared register map and field constants for the Qsys interrupt controller.
package de10_standard_qsys_irq_pkg;

  localparam int DATA_W        = 16;
  localparam int IDX_W         = 4;
  localparam int VEC_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_RAW      = 3'd3;
  localparam logic [2:0] ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] ADDR_FORCE    = 3'd5;

endpackage

// File: rtl/de10_standard_qsys_irq_prio_enc.sv
// Combinational lowest-index priority encoder used to build the VECTOR register.
module de10_standard_qsys_irq_prio_enc
  import de10_standard_qsys_irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/de10_standard_qsys_irq_ctrl.sv
// Avalon-MM interrupt controller: synchronised sources, edge/level pending,
// mask, software force, lowest-index vector and aggregated irq.
module de10_standard_qsys_irq_ctrl
  import de10_standard_qsys_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_IRQ-1:0] sync1_q, sync_q, hist_q;
  logic [NUM_IRQ-1:0] epend_q, epend_d;
  logic [NUM_IRQ-1:0] frc_q, frc_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [1:0]         vld_q, vld_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               irq_q, irq_d;

  logic               wr;
  logic [NUM_IRQ-1:0] wdata, w1c, frc_wr, edge_det, sel_fall, pending, active;
  logic               det_en, vec_valid;
  logic [IDX_W-1:0]   vec_idx;
  logic [DATA_W-1:0]  vector;

  de10_standard_qsys_irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req   (active),
    .valid (vec_valid),
    .idx   (vec_idx)
  );

  always_comb begin
    wr     = chipselect & ~write_n;
    wdata  = writedata[NUM_IRQ-1:0];
    w1c    = (wr && address == ADDR_PENDING) ? wdata : '0;
    frc_wr = (wr && address == ADDR_FORCE)   ? wdata : '0;

    mask_d     = (wr && address == ADDR_MASK)     ? wdata : mask_q;
    edge_sel_d = (wr && address == ADDR_EDGE_SEL) ? wdata : edge_sel_q;
    sel_fall   = edge_sel_q & ~edge_sel_d;

    // History is cleared in reset, so edges are ignored until sync_q has
    // carried real input data into hist_q.
    det_en   = (vld_q == 2'd3);
    vld_d    = det_en ? vld_q : vld_q + 2'd1;
    edge_det = det_en ? (sync_q & ~hist_q & edge_sel_q) : '0;

    // New edges and forces are OR'd in after the clear, so set wins.
    epend_d = (epend_q & ~w1c & ~sel_fall) | edge_det;
    frc_d   = (frc_q & ~w1c) | frc_wr;

    pending = (epend_q & edge_sel_q) | frc_q | (sync_q & ~edge_sel_q);
    active  = pending & mask_q;
    irq_d   = |active;

    vector = '0;
    if (vec_valid) begin
      vector[VEC_VALID_BIT] = 1'b1;
      vector[IDX_W-1:0]     = vec_idx;
    end

    unique case (address)
      ADDR_PENDING:  readdata_d = DATA_W'(pending);
      ADDR_MASK:     readdata_d = DATA_W'(mask_q);
      ADDR_EDGE_SEL: readdata_d = DATA_W'(edge_sel_q);
      ADDR_RAW:      readdata_d = DATA_W'(sync_q);
      ADDR_VECTOR:   readdata_d = vector;
      default:       readdata_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      hist_q     <= '0;
      epend_q    <= '0;
      frc_q      <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      vld_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= irq_in;
      sync_q     <= sync1_q;
      hist_q     <= sync_q;
      epend_q    <= epend_d;
      frc_q      <= frc_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      vld_q      <= vld_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_de10_standard_qsys_irq_ctrl.sv
// Directed self-checking bench for the Qsys interrupt controller.
module tb_de10_standard_qsys_irq_ctrl;

  localparam logic [2:0] A_PEND = 3'd0, A_MASK = 3'd1, A_EDGE = 3'd2,
                         A_RAW = 3'd3, A_VEC = 3'd4, A_FORCE = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = '0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  de10_standard_qsys_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1 d = readdata;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    #2;
    n_cmp++;
    if (readdata !== 16'h0 || irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: readdata=%h irq=%b want 0000/0", readdata, irq);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      n_cmp++;
      if (d !== 16'h0) begin
        n_bad++; $display("FAIL reset_reg%0d: got %h want 0000", a, d);
      end
    end
  endtask

  task automatic test_edge_pulse;
    logic [15:0] d;
    wr_reg(A_MASK, 16'h0001);
    wr_reg(A_EDGE, 16'h0001);
    @(negedge clk); irq_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_bad++; $display("FAIL edge_pending: got %h want 0001", d); end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL edge_irq: got %b want 1", irq); end
    rd_reg(A_VEC, d);
    n_cmp++;
    if (d !== 16'h8000) begin n_bad++; $display("FAIL edge_vector: got %h want 8000", d); end
    wr_reg(A_PEND, 16'h0001);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL edge_w1c: got %h want 0000", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL edge_w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_level;
    logic [15:0] d;
    wr_reg(A_EDGE, 16'h0000);
    wr_reg(A_MASK, 16'h0004);
    @(negedge clk); irq_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL level_irq: got %b want 1", irq); end
    wr_reg(A_PEND, 16'h0004);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL level_irq_after_w1c: got %b want 1", irq); end
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0004) begin n_bad++; $display("FAIL level_pending: got %h want 0004", d); end
    @(negedge clk); irq_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL level_release_irq: got %b want 0", irq); end
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL level_release_pend: got %h want 0000", d); end
  endtask

  task automatic test_set_wins;
    logic [15:0] d;
    wr_reg(A_EDGE, 16'h0008);
    wr_reg(A_MASK, 16'h0008);
    @(negedge clk); irq_in[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    // sync_q is now high with history still low: the W1C lands on the detect cycle.
    wr_reg(A_PEND, 16'h0008);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0008) begin n_bad++; $display("FAIL set_wins_pending: got %h want 0008", d); end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL set_wins_irq: got %b want 1", irq); end
    wr_reg(A_PEND, 16'h0008);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL set_wins_clear: got %h want 0000", d); end
    irq_in[3] = 1'b0;
    wr_reg(A_EDGE, 16'h0000);
  endtask

  task automatic test_force;
    logic [15:0] d;
    wr_reg(A_MASK, 16'h0000);
    wr_reg(A_FORCE, 16'h0030);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0030) begin n_bad++; $display("FAIL force_pending: got %h want 0030", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL force_masked_irq: got %b want 0", irq); end
    rd_reg(A_VEC, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL force_masked_vec: got %h want 0000", d); end
    rd_reg(A_FORCE, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL force_readback: got %h want 0000", d); end
    wr_reg(A_MASK, 16'h0020);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL unmask_early: got %b want 0", irq); end
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL unmask_irq: got %b want 1", irq); end
    rd_reg(A_VEC, d);
    n_cmp++;
    if (d !== 16'h8005) begin n_bad++; $display("FAIL unmask_vec: got %h want 8005", d); end
    wr_reg(A_FORCE, 16'h000C);
    wr_reg(A_MASK, 16'h00FF);
    rd_reg(A_VEC, d);
    n_cmp++;
    if (d !== 16'h8002) begin n_bad++; $display("FAIL prio_vec: got %h want 8002", d); end
    wr_reg(A_PEND, 16'h003C);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL force_w1c: got %h want 0000", d); end
    wr_reg(3'd6, 16'hFFFF);
    rd_reg(3'd6, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL addr6: got %h want 0000", d); end
  endtask

  task automatic test_raw;
    logic [15:0] d;
    @(negedge clk); irq_in = 8'hA5;
    repeat (3) @(negedge clk);
    rd_reg(A_RAW, d);
    n_cmp++;
    if (d !== 16'h00A5) begin n_bad++; $display("FAIL raw: got %h want 00a5", d); end
    rd_reg(A_VEC, d);
    n_cmp++;
    if (d !== 16'h8000) begin n_bad++; $display("FAIL raw_vec: got %h want 8000", d); end
    irq_in = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_edges;
    logic [15:0] d;
    @(negedge clk);
    irq_in = 8'hFF;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_reg(A_EDGE, 16'h00FF);
    wr_reg(A_MASK, 16'h00FF);
    repeat (4) @(negedge clk);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL no_edge_after_reset: got %h want 0000", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL no_edge_irq: got %b want 0", irq); end
    wr_reg(A_FORCE, 16'h00FF);
    rd_reg(A_PEND, d);
    n_cmp++;
    if (d !== 16'h00FF) begin n_bad++; $display("FAIL pre_reset_pend: got %h want 00ff", d); end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (irq !== 1'b0 || readdata !== 16'h0000) begin
      n_bad++; $display("FAIL async_reset: irq=%b readdata=%h want 0/0000", irq, readdata);
    end
    irq_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd_reg(3'(a), d);
      n_cmp++;
      if (d !== 16'h0000) begin n_bad++; $display("FAIL post_reset_reg%0d: got %h want 0000", a, d); end
    end
  endtask

  initial begin
    test_reset();
    test_edge_pulse();
    test_level();
    test_set_wins();
    test_force();
    test_raw();
    test_reset_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/de10_standard_qsys_irq_ctrl.md
DE10_STANDARD_QSYS_IRQ_CTRL -- requirements
Module: de10_standard_qsys_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, meaning the number of interrupt source inputs (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single system clock for all logic.
REQ-003 SHALL have port reset, input, 1, active-high asynchronous reset.
REQ-004 SHALL have port irq_in, input, NUM_IRQ, interrupt sources (e.g. sys_clk_timer irq), possibly asynchronous to clk.
REQ-005 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-006 SHALL have port address, input, 3, register word address.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 16, write data.
REQ-009 SHALL have port readdata, output, 16, registered read data.
REQ-010 SHALL have port irq, output, 1, aggregated interrupt request to the CPU.

Function
REQ-011 SHALL synchronise irq_in through two flops (sync_q); all further logic uses sync_q only.
REQ-012 SHALL register map: 0 PENDING (R, W1C), 1 MASK (RW), 2 EDGE_SEL (RW; 1=rising edge, 0=level), 3 RAW (R, sync_q), 4 VECTOR (R), 5 FORCE (W-only, reads 0); addresses 6-7 read 0, writes ignored.
REQ-013 SHALL treat a write as chipselect=1 and write_n=0 in the same cycle; the register updates on the next clk edge.
REQ-014 SHALL register readdata every cycle from the address mux, giving 1-cycle read latency independent of chipselect; unused upper bits read 0.
REQ-015 SHALL set edge-mode pending bit i on the cycle after sync_q[i] transitions 0->1 with EDGE_SEL[i]=1.
REQ-016 SHALL make level-mode pending bit i (EDGE_SEL[i]=0) follow sync_q[i] OR'd with its FORCE-set state; W1C clears only the FORCE-set state.
REQ-017 SHALL clear edge pending bits on W1C to PENDING with writedata[i]=1; bits written 0 are unchanged.
REQ-018 SHALL give set priority over clear when a new edge or FORCE and a W1C hit the same bit in the same cycle (bit stays 1).
REQ-019 SHALL set pending bits for each writedata[i]=1 written to FORCE, regardless of EDGE_SEL.
REQ-020 SHALL drive irq registered as OR of (PENDING & MASK), asserting 1 cycle after the contributing pending bit is set.
REQ-021 SHALL report VECTOR as bit15=valid (any PENDING & MASK), bits[3:0]=lowest-numbered index in PENDING & MASK, bits[14:4]=0; VECTOR=0 when none is valid.
REQ-022 SHALL keep pending bits recorded while masked; unmasking a pending bit asserts irq on the following cycle.
REQ-023 SHALL clear a stale edge pending bit when EDGE_SEL changes 1->0 for that bit; a 0->1 change SHALL NOT create an edge.

Reset
REQ-024 SHALL, on reset assertion, asynchronously clear sync flops, edge-history flops, PENDING, FORCE state, MASK, EDGE_SEL, readdata and irq to 0.
REQ-025 SHALL NOT detect an edge on the first cycle after reset release when irq_in is already high (history resets to 0, but detection is gated until sync_q is valid, two cycles).

Structure
REQ-026 SHALL place register address constants (ADDR_PENDING..ADDR_FORCE) and the VECTOR valid-bit position in shared package de10_standard_qsys_irq_pkg.
REQ-027 SHALL instantiate one sub-module, de10_standard_qsys_irq_prio_enc (NUM_IRQ-wide lowest-index priority encoder, combinational), for VECTOR.

Verification
REQ-028 SHALL cover: MASK=0x01, EDGE_SEL=0x01, pulse irq_in[0] high 3 cycles -> PENDING=0x0001, irq=1, VECTOR=0x8000; W1C 0x0001 -> PENDING=0, irq=0.
REQ-029 SHALL cover: level mode bit 2 with MASK=0x04, hold irq_in[2]=1 -> irq stays 1 through W1C 0x0004; deassert input -> irq=0 within 4 cycles.
REQ-030 SHALL cover: edge on bit 3 in the same cycle as W1C 0x0008 -> PENDING bit 3 remains 1.
REQ-031 SHALL cover: MASK=0, FORCE 0x0030 -> PENDING=0x0030, irq=0, VECTOR=0x0000; MASK=0x0020 -> irq=1 next cycle, VECTOR=0x8005.
REQ-032 SHALL cover: irq_in=0xFF held through reset release -> no PENDING bits set in edge mode; reset asserted mid-operation with PENDING=0x00FF -> all registers and irq read 0 immediately.
